// File: rtl/stopwatch_pkg.sv
// Shared encodings and defaults for the stopwatch control sequencer.
// Imported by the control block and its input debouncers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJ    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CM_FULL = 2'b00,
        CM_MIN  = 2'b01,
        CM_SEC  = 2'b10
    } cnt_mode_e;

    // 5 ms of stability at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
    localparam int unsigned DB_W_DEF            = 19;

endpackage

// File: rtl/stopwatch_debounce.sv
// Two-flop synchroniser followed by a stability counter; emits either the
// debounced level or a one-cycle pulse on its rising edge.
module stopwatch_debounce #(
    parameter int unsigned CYCLES  = 4,
    parameter int unsigned W       = 3,
    parameter bit          EDGE    = 1'b0,
    parameter bit          RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic out
);

    logic         s1_q, s1_d;
    logic         s2_q, s2_d;
    logic         lvl_q, lvl_d;
    logic         prev_q, prev_d;
    logic [W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronised samples that disagree with the
    // accepted level; any agreeing sample restarts the count.
    always_comb begin
        s1_d   = raw;
        s2_d   = s1_q;
        prev_d = lvl_q;
        lvl_d  = lvl_q;
        cnt_d  = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q >= W'(CYCLES - 1)) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Buttons reset their level high so a press held through reset is
    // treated as already seen and must be released before it can pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            lvl_q  <= RST_LVL;
            prev_q <= RST_LVL;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            prev_q <= prev_d;
        end
    end

    assign out = EDGE ? (lvl_q & ~prev_q) : lvl_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced buttons/switches drive a
// PAUSED/RUN/ADJ state machine, counter commands and the adjust blink mask.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned DB_W            = DB_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    input  logic       unit_tick,
    input  logic       fast_tick,
    input  logic       blink_tick,
    output logic       cnt_inc,
    output logic [1:0] cnt_mode,
    output logic       cnt_clear,
    output logic [3:0] blank_an,
    output logic       running
);

    logic pause_pulse, reset_pulse, adj_lvl, sel_lvl;

    stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES), .W(DB_W), .EDGE(1'b1), .RST_LVL(1'b1))
        u_db_pause (.clk(clk), .rst_n(rst_n), .raw(btn_pause), .out(pause_pulse));
    stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES), .W(DB_W), .EDGE(1'b1), .RST_LVL(1'b1))
        u_db_reset (.clk(clk), .rst_n(rst_n), .raw(btn_reset), .out(reset_pulse));
    stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES), .W(DB_W), .EDGE(1'b0), .RST_LVL(1'b0))
        u_db_adj   (.clk(clk), .rst_n(rst_n), .raw(sw_adj), .out(adj_lvl));
    stopwatch_debounce #(.CYCLES(DEBOUNCE_CYCLES), .W(DB_W), .EDGE(1'b0), .RST_LVL(1'b0))
        u_db_sel   (.clk(clk), .rst_n(rst_n), .raw(sw_sel), .out(sel_lvl));

    state_e    state_q, state_d;
    cnt_mode_e mode_q, mode_d;
    logic      inc_q, inc_d;
    logic      clear_q, clear_d;
    logic      phase_q, phase_d;
    logic      sel_q, sel_d;

    // Adjust switch wins over any pending pause press.
    always_comb begin
        state_d = state_q;
        if (adj_lvl) begin
            state_d = ADJ;
        end else begin
            case (state_q)
                ADJ:     state_d = PAUSED;
                RUN:     if (pause_pulse) state_d = PAUSED;
                PAUSED:  if (pause_pulse) state_d = RUN;
                default: state_d = PAUSED;
            endcase
        end
    end

    always_comb begin
        inc_d   = 1'b0;
        mode_d  = CM_FULL;
        clear_d = reset_pulse;
        case (state_q)
            RUN: inc_d = unit_tick;
            ADJ: begin
                inc_d  = fast_tick;
                mode_d = sel_lvl ? CM_SEC : CM_MIN;
            end
            default: inc_d = 1'b0;
        endcase
        // A clear swallows the tick that coincides with it.
        if (reset_pulse) inc_d = 1'b0;
    end

    // Phase restarts visible whenever adjust is entered or the field changes.
    always_comb begin
        sel_d   = sel_lvl;
        phase_d = 1'b0;
        if (state_q == ADJ && sel_lvl == sel_q) begin
            phase_d = phase_q ^ blink_tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAUSED;
            mode_q  <= CM_FULL;
            inc_q   <= 1'b0;
            clear_q <= 1'b0;
            phase_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            inc_q   <= inc_d;
            clear_q <= clear_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
        end
    end

    assign cnt_inc   = inc_q;
    assign cnt_mode  = mode_q;
    assign cnt_clear = clear_q;
    assign running   = (state_q == RUN);
    assign blank_an  = (state_q == ADJ) ?
                       {{2{~sel_q & phase_q}}, {2{sel_q & phase_q}}} : 4'b0000;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a short debounce window; a behavioural
// model tracks expected outputs every cycle alongside directed scenarios.
module tb_stopwatch_ctrl;

    localparam int DC = 4;
    localparam int M_PAUSED = 0, M_RUN = 1, M_ADJ = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_pause = 1'b0, btn_reset = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic       unit_tick = 1'b0, fast_tick = 1'b0, blink_tick = 1'b0;
    logic       cnt_inc, cnt_clear, running;
    logic [1:0] cnt_mode;
    logic [3:0] blank_an;

    int errors = 0;
    int checks = 0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DC), .DB_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_pause(btn_pause), .btn_reset(btn_reset),
        .sw_adj(sw_adj), .sw_sel(sw_sel),
        .unit_tick(unit_tick), .fast_tick(fast_tick), .blink_tick(blink_tick),
        .cnt_inc(cnt_inc), .cnt_mode(cnt_mode), .cnt_clear(cnt_clear),
        .blank_an(blank_an), .running(running)
    );

    initial forever #5 clk = ~clk;

    wire [8:0] dut_vec = {cnt_inc, cnt_mode, cnt_clear, blank_an, running};

    // ---------------- reference model ----------------
    // hist holds the raw input samples as the debouncer sees them (two
    // synchroniser stages deep); a level flips once DC samples in a row differ.
    logic [3:0] hist[$];
    logic [3:0] m_lvl;      // {sel, adj, reset, pause}
    logic [1:0] m_pulse;    // {reset, pause}
    int         m_st;
    logic       m_phase, m_selq, m_diff;
    logic       exp_inc, exp_clear;
    logic [1:0] exp_mode;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            hist.push_back(4'b0);
            hist.push_back(4'b0);
            m_lvl = 4'b0011;
            m_pulse = 2'b00;
            m_st = M_PAUSED;
            m_phase = 1'b0;
            m_selq = 1'b0;
            exp_inc = 1'b0;
            exp_clear = 1'b0;
            exp_mode = 2'b00;
        end else begin
            exp_clear = m_pulse[1];
            exp_inc = !m_pulse[1] && ((m_st == M_RUN && unit_tick) || (m_st == M_ADJ && fast_tick));
            exp_mode = (m_st == M_ADJ) ? (m_lvl[3] ? 2'b10 : 2'b01) : 2'b00;
            if (m_st != M_ADJ || m_lvl[3] != m_selq) m_phase = 1'b0;
            else if (blink_tick) m_phase = ~m_phase;
            m_selq = m_lvl[3];
            if (m_lvl[2]) m_st = M_ADJ;
            else if (m_st == M_ADJ) m_st = M_PAUSED;
            else if (m_pulse[0]) m_st = (m_st == M_RUN) ? M_PAUSED : M_RUN;
            hist.push_back({sw_sel, sw_adj, btn_reset, btn_pause});
            if (hist.size() > DC + 2) void'(hist.pop_front());
            m_pulse = 2'b00;
            if (hist.size() == DC + 2) begin
                for (int i = 0; i < 4; i++) begin
                    m_diff = 1'b1;
                    for (int k = 0; k < DC; k++) if (hist[k][i] == m_lvl[i]) m_diff = 1'b0;
                    if (m_diff) begin
                        m_lvl[i] = ~m_lvl[i];
                        if (i < 2 && m_lvl[i]) m_pulse[i[0]] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [8:0] exp_vec();
        logic [3:0] b;
        b = 4'b0000;
        if (m_st == M_ADJ) b = {{2{~m_selq & m_phase}}, {2{m_selq & m_phase}}};
        return {exp_inc, exp_mode, exp_clear, b, (m_st == M_RUN)};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        {btn_pause, btn_reset, sw_adj, sw_sel, unit_tick, fast_tick, blink_tick} = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 9'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 9'b0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec() || dut_vec !== 9'b0) begin
                errors++; $display("FAIL reset_settle got=%b exp=%b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_pause_start();
        int trans = 0;
        logic prev = 1'b0;
        for (int k = 0; k < 10; k++) begin
            btn_pause = 1'b1;
            @(negedge clk);
            checks++;
            if (running !== (k >= 6)) begin
                errors++; $display("FAIL start_latency k=%0d got=%b exp=%b", k, running, (k >= 6));
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL start_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
            end
            if (running && !prev) trans++;
            prev = running;
        end
        checks++;
        if (trans !== 1) begin
            errors++; $display("FAIL start_transitions got=%0d exp=1", trans);
        end
        btn_pause = 1'b0;
        repeat (8) @(negedge clk);
        for (int t = 0; t < 3; t++) begin
            unit_tick = 1'b1;
            @(negedge clk);
            unit_tick = 1'b0;
            checks++;
            if (cnt_inc !== 1'b1 || cnt_mode !== 2'b00) begin
                errors++; $display("FAIL run_inc got=%b/%b exp=1/00", cnt_inc, cnt_mode);
            end
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                checks++;
                if (cnt_inc !== 1'b0) begin
                    errors++; $display("FAIL run_idle got=%b exp=0", cnt_inc);
                end
            end
        end
    endtask

    task automatic test_clear_pulse();
        int clears = 0;
        btn_reset = 1'b1;
        repeat (2) @(negedge clk);
        btn_reset = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (cnt_clear) clears++;
        end
        checks++;
        if (clears !== 0) begin
            errors++; $display("FAIL clear_glitch got=%0d exp=0", clears);
        end
        btn_reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (cnt_clear) clears++;
        end
        btn_reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (cnt_clear) clears++;
        end
        checks++;
        if (clears !== 1) begin
            errors++; $display("FAIL clear_held got=%0d exp=1", clears);
        end
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL clear_state got=%b exp=1", running);
        end
    endtask

    task automatic test_clear_priority();
        for (int k = 0; k < 10; k++) begin
            btn_reset = 1'b1;
            unit_tick = (k == 6);
            @(negedge clk);
            if (k == 6) begin
                checks++;
                if (cnt_clear !== 1'b1 || cnt_inc !== 1'b0) begin
                    errors++; $display("FAIL clear_priority got=%b/%b exp=1/0", cnt_clear, cnt_inc);
                end
            end
        end
        unit_tick = 1'b0;
        btn_reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL clear_keeps_run got=%b exp=1", running);
        end
    endtask

    task automatic test_adjust();
        sw_adj = 1'b1;
        sw_sel = 1'b0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL adj_entry_model got=%b exp=%b", dut_vec, exp_vec());
            end
        end
        checks++;
        if (running !== 1'b0 || blank_an !== 4'b0000) begin
            errors++; $display("FAIL adj_entry got=%b/%b exp=0/0000", running, blank_an);
        end
        fast_tick = 1'b1;
        @(negedge clk);
        fast_tick = 1'b0;
        checks++;
        if (cnt_inc !== 1'b1 || cnt_mode !== 2'b01) begin
            errors++; $display("FAIL adj_fast got=%b/%b exp=1/01", cnt_inc, cnt_mode);
        end
        unit_tick = 1'b1;
        @(negedge clk);
        unit_tick = 1'b0;
        checks++;
        if (cnt_inc !== 1'b0) begin
            errors++; $display("FAIL adj_unit_ignored got=%b exp=0", cnt_inc);
        end
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
        checks++;
        if (blank_an !== 4'b1100) begin
            errors++; $display("FAIL blink_on got=%b exp=1100", blank_an);
        end
        @(negedge clk);
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
        checks++;
        if (blank_an !== 4'b0000) begin
            errors++; $display("FAIL blink_off got=%b exp=0000", blank_an);
        end
    endtask

    task automatic test_sel_flip();
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
        checks++;
        if (blank_an !== 4'b1100) begin
            errors++; $display("FAIL sel_pre got=%b exp=1100", blank_an);
        end
        sw_sel = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL sel_model got=%b exp=%b", dut_vec, exp_vec());
            end
        end
        checks++;
        if (blank_an !== 4'b0000 || cnt_mode !== 2'b10) begin
            errors++; $display("FAIL sel_restart got=%b/%b exp=0000/10", blank_an, cnt_mode);
        end
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
        checks++;
        if (blank_an !== 4'b0011) begin
            errors++; $display("FAIL sel_blink got=%b exp=0011", blank_an);
        end
    endtask

    task automatic test_adj_exit_and_reset();
        sw_adj = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (running !== 1'b0 || blank_an !== 4'b0000 || cnt_mode !== 2'b00) begin
            errors++; $display("FAIL adj_exit got=%b/%b/%b exp=0/0000/00", running, blank_an, cnt_mode);
        end
        sw_adj = 1'b1;
        repeat (10) @(negedge clk);
        btn_pause = 1'b1;
        repeat (10) @(negedge clk);
        btn_pause = 1'b0;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec() || running !== 1'b0) begin
                errors++; $display("FAIL adj_pause_ignored got=%b exp=%b", dut_vec, exp_vec());
            end
        end
        sw_adj = 1'b0;
        repeat (10) @(negedge clk);
        btn_pause = 1'b1;
        repeat (10) @(negedge clk);
        btn_pause = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL rerun got=%b exp=1", running);
        end
        btn_pause = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 9'b0) begin
            errors++; $display("FAIL async_reset got=%b exp=%b", dut_vec, 9'b0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            checks++;
            if (running !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL held_through_reset got=%b exp=%b", dut_vec, exp_vec());
            end
        end
        btn_pause = 1'b0;
        repeat (8) @(negedge clk);
        btn_pause = 1'b1;
        repeat (10) @(negedge clk);
        btn_pause = 1'b0;
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL repress_after_reset got=%b exp=1", running);
        end
    endtask

    task automatic test_random();
        int hold[4] = '{0, 0, 0, 0};
        logic [3:0] raw;
        raw = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    raw[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 9);
                end
                hold[i]--;
            end
            {sw_sel, sw_adj, btn_reset, btn_pause} = raw;
            unit_tick  = ($urandom_range(0, 3) == 0);
            fast_tick  = ($urandom_range(0, 3) == 0);
            blink_tick = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec, exp_vec());
            end
        end
        {btn_pause, btn_reset, sw_adj, sw_sel, unit_tick, fast_tick, blink_tick} = '0;
    endtask

    initial begin
        test_reset();
        test_pause_start();
        test_clear_pulse();
        test_clear_priority();
        test_adjust();
        test_sel_flip();
        test_adj_exit_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
